onchip_memory_arbiter: RTL and testbench

Two-master arbiter that shares the single-port 40000x32 on-chip RAM between a video scan-out reader (m0) and the Nios data master (m1). It sits between the two Avalon-MM masters and the RAM's s1 port. It issues at most one command per clock, tracks the one-cycle read latency of the unregistered RAM output, and bounds how long either master can monopolise the port. Out-of-range addresses are blocked at the RAM boundary.

---
 rtl/onchip_memory_arbiter_if.sv | 61 ++++++
 rtl/onchip_memory_arbiter.sv | 117 +++++++++++
 tb/tb_onchip_memory_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_memory_arbiter_if.sv
// Bus bundle between two Avalon-MM masters, the arbiter and the RAM s1 port.
// master = environment side (masters + RAM), slave = arbiter side.
interface onchip_memory_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m0_address;
  logic [DATA_W/8-1:0] m0_byteenable;
  logic                m0_read;
  logic                m0_write;
  logic [DATA_W-1:0]   m0_writedata;
  logic                m0_waitrequest;
  logic [DATA_W-1:0]   m0_readdata;
  logic                m0_readdatavalid;

  logic [ADDR_W-1:0]   m1_address;
  logic [DATA_W/8-1:0] m1_byteenable;
  logic                m1_read;
  logic                m1_write;
  logic [DATA_W-1:0]   m1_writedata;
  logic                m1_waitrequest;
  logic [DATA_W-1:0]   m1_readdata;
  logic                m1_readdatavalid;

  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W-1:0]   mem_readdata;

  modport master (
    output m0_address, m0_byteenable, m0_read,
    output m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata,
    input  m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read,
    output m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata,
    input  m1_readdatavalid,
    input  mem_address, mem_byteenable,
    input  mem_chipselect, mem_write,
    input  mem_writedata,
    output mem_readdata
  );

  modport slave (
    input  m0_address, m0_byteenable, m0_read,
    input  m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata,
    output m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read,
    input  m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata,
    output m1_readdatavalid,
    output mem_address, mem_byteenable,
    output mem_chipselect, mem_write,
    output mem_writedata,
    input  mem_readdata
  );
endinterface

// File: rtl/onchip_memory_arbiter.sv
// Two-master arbiter for the single-port on-chip RAM: one command per
// clock, bounded hold per master, 1-cycle read return, range blocking.
module onchip_memory_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 40000,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  onchip_memory_arbiter_if.slave   bus
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] LP_DEPTH =
    (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0] LP_MAX = 8'(MAX_HOLD);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  owner_e     r_owner;
  logic [7:0] r_hold;
  logic       r_rsp_vld;
  logic       r_rsp_port;
  logic       r_rsp_oor;

  logic              w_req0;
  logic              w_req1;
  logic              w_gv;
  logic              w_g;
  logic [ADDR_W-1:0] w_addr;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wd;
  logic              w_wr;
  logic              w_rd;
  logic              w_oor;
  logic              w_rd_issue;

  assign w_req0 = bus.m0_read | bus.m0_write;
  assign w_req1 = bus.m1_read | bus.m1_write;

  // Grant selection: lone requester wins, contention honours hold limit.
  always_comb begin
    w_gv = 1'b0;
    w_g  = r_owner;
    if (!reset) begin
      if (w_req0 && w_req1) begin
        w_gv = 1'b1;
        w_g  = (r_hold < LP_MAX) ? r_owner : ~r_owner;
      end else if (w_req0) begin
        w_gv = 1'b1;
        w_g  = 1'b0;
      end else if (w_req1) begin
        w_gv = 1'b1;
        w_g  = 1'b1;
      end
    end
  end

  // Command mux from the granted master; write wins over read.
  always_comb begin
    w_addr = w_g ? bus.m1_address    : bus.m0_address;
    w_be   = w_g ? bus.m1_byteenable : bus.m0_byteenable;
    w_wd   = w_g ? bus.m1_writedata  : bus.m0_writedata;
    w_wr   = w_g ? bus.m1_write      : bus.m0_write;
    w_rd   = w_g ? bus.m1_read       : bus.m0_read;
    w_oor  = {1'b0, w_addr} >= LP_DEPTH;
    w_rd_issue = w_gv & w_rd & ~w_wr;
  end

  assign bus.mem_address    = w_addr;
  assign bus.mem_byteenable = w_be;
  assign bus.mem_writedata  = w_wd;
  assign bus.mem_chipselect = w_gv & ~w_oor;
  assign bus.mem_write      = w_gv & w_wr & ~w_oor;

  assign bus.m0_waitrequest = ~(w_gv & ~w_g);
  assign bus.m1_waitrequest = ~(w_gv & w_g);

  // Out-of-range reads never touched the RAM, so force zero data.
  assign bus.m0_readdata = r_rsp_oor ? '0 : bus.mem_readdata;
  assign bus.m1_readdata = r_rsp_oor ? '0 : bus.mem_readdata;

  // A response due in a reset cycle is dropped.
  assign bus.m0_readdatavalid =
    r_rsp_vld & ~r_rsp_port & ~reset;
  assign bus.m1_readdatavalid =
    r_rsp_vld &  r_rsp_port & ~reset;

  // Ownership/hold tracking and read-response pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner    <= OWN_M0;
      r_hold     <= 8'd0;
      r_rsp_vld  <= 1'b0;
      r_rsp_port <= 1'b0;
      r_rsp_oor  <= 1'b0;
    end else begin
      r_rsp_vld  <= w_rd_issue;
      r_rsp_port <= w_g;
      r_rsp_oor  <= w_oor;
      if (w_gv) begin
        if (owner_e'(w_g) == r_owner) begin
          if (r_hold != 8'hFF)
            r_hold <= r_hold + 8'd1;
        end else begin
          r_owner <= owner_e'(w_g);
          r_hold  <= 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: directed table, fairness and reset
// sequences, then random traffic against a behavioural model.
module tb_onchip_memory_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 40000;
  localparam int MAXH  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  onchip_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  onchip_memory_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .DEPTH(DEPTH), .MAX_HOLD(MAXH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // RAM with registered read data (valid the cycle after address)
  bit   [31:0] ram [DEPTH];
  logic [31:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b])
            ram[int'(bus.mem_address)][8*b +: 8] <=
              bus.mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[int'(bus.mem_address)];
      end
    end
  end
  assign bus.mem_readdata = ram_q;

  typedef struct {
    bit          rst;
    bit          r0, w0;
    logic [15:0] a0;
    logic [31:0] d0;
    bit          r1, w1;
    logic [15:0] a1;
    logic [31:0] d1;
    logic [3:0]  be;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          wq0, wq1, cs, mw, v0, v1;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    bit          wq0, wq1, cs, mw, v0, v1;
    logic [15:0] ma;
    logic [31:0] rd;
  } exp_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic stim_t st(
    bit rst, bit r0, bit w0, logic [15:0] a0, logic [31:0] d0,
    bit r1, bit w1, logic [15:0] a1, logic [31:0] d1,
    logic [3:0] be);
    stim_t s;
    s.rst = rst; s.r0 = r0; s.w0 = w0; s.a0 = a0; s.d0 = d0;
    s.r1 = r1; s.w1 = w1; s.a1 = a1; s.d1 = d1; s.be = be;
    return s;
  endfunction

  function automatic vec_t vx(stim_t s, bit wq0, bit wq1,
    bit cs, bit mw, bit v0, bit v1, logic [31:0] rd);
    vec_t v;
    v.s = s; v.wq0 = wq0; v.wq1 = wq1; v.cs = cs; v.mw = mw;
    v.v0 = v0; v.v1 = v1; v.rd = rd;
    return v;
  endfunction

  task automatic drive(stim_t s);
    @(negedge clk);
    reset             = s.rst;
    bus.m0_read       = s.r0;
    bus.m0_write      = s.w0;
    bus.m0_address    = s.a0;
    bus.m0_writedata  = s.d0;
    bus.m0_byteenable = s.be;
    bus.m1_read       = s.r1;
    bus.m1_write      = s.w1;
    bus.m1_address    = s.a1;
    bus.m1_writedata  = s.d1;
    bus.m1_byteenable = s.be;
    #1;
  endtask

  // Reference model: who owns the port, how long, memory image,
  // and the one outstanding read response.
  int          m_cur = 0;
  int          m_run = 0;
  bit          p_v   = 0;
  int          p_port = 0;
  logic [31:0] p_data = '0;
  bit   [31:0] mm [DEPTH];

  task automatic mdl(input stim_t s, output exp_t e);
    bit q0, q1, wr;
    int g, a;
    logic [31:0] d;
    e.v0  = p_v && !s.rst && p_port == 0;
    e.v1  = p_v && !s.rst && p_port == 1;
    e.rd  = p_data;
    e.wq0 = 1; e.wq1 = 1; e.cs = 0; e.mw = 0; e.ma = '0;
    if (s.rst) begin
      m_cur = 0; m_run = 0; p_v = 0;
      return;
    end
    q0 = s.r0 | s.w0;
    q1 = s.r1 | s.w1;
    if (!q0 && !q1) begin
      p_v = 0;
      return;
    end
    if (q0 && q1) g = (m_run < MAXH) ? m_cur : 1 - m_cur;
    else g = q1 ? 1 : 0;
    if (g == m_cur) m_run = (m_run < 255) ? m_run + 1 : 255;
    else begin m_cur = g; m_run = 1; end
    wr = g ? s.w1 : s.w0;
    a  = g ? int'(s.a1) : int'(s.a0);
    d  = g ? s.d1 : s.d0;
    e.wq0 = (g != 0);
    e.wq1 = (g != 1);
    e.cs  = (a < DEPTH);
    e.mw  = wr && (a < DEPTH);
    e.ma  = 16'(a);
    if (wr) begin
      p_v = 0;
      if (a < DEPTH)
        for (int b = 0; b < 4; b++)
          if (s.be[b]) mm[a][8*b +: 8] = d[8*b +: 8];
    end else begin
      p_v    = 1;
      p_port = g;
      p_data = (a < DEPTH) ? mm[a] : 32'h0;
    end
  endtask

  task automatic chk_model(string tag, exp_t e);
    chk({tag, " wait0"}, 32'(bus.m0_waitrequest), 32'(e.wq0));
    chk({tag, " wait1"}, 32'(bus.m1_waitrequest), 32'(e.wq1));
    chk({tag, " cs"}, 32'(bus.mem_chipselect), 32'(e.cs));
    chk({tag, " mwr"}, 32'(bus.mem_write), 32'(e.mw));
    if (e.cs) chk({tag, " maddr"}, 32'(bus.mem_address), 32'(e.ma));
    chk({tag, " rdv0"}, 32'(bus.m0_readdatavalid), 32'(e.v0));
    chk({tag, " rdv1"}, 32'(bus.m1_readdatavalid), 32'(e.v1));
    if (e.v0) chk({tag, " rd0"}, bus.m0_readdata, e.rd);
    if (e.v1) chk({tag, " rd1"}, bus.m1_readdata, e.rd);
  endtask

  vec_t  tbl [15];
  stim_t idle, rsti;
  exp_t  e;

  initial begin
    reset = 1'b1;
    bus.m0_read = 0; bus.m0_write = 0; bus.m0_address = '0;
    bus.m0_writedata = '0; bus.m0_byteenable = '0;
    bus.m1_read = 0; bus.m1_write = 0; bus.m1_address = '0;
    bus.m1_writedata = '0; bus.m1_byteenable = '0;

    idle = st(0, 0,0,16'h0,32'h0, 0,0,16'h0,32'h0, 4'hF);
    rsti = st(1, 0,0,16'h0,32'h0, 0,0,16'h0,32'h0, 4'hF);

    tbl[0]  = vx(st(1, 1,0,16'h0005,32'h0, 1,0,16'h0006,32'h0, 4'hF),
                 1,1,0,0, 0,0, 32'h0);
    tbl[1]  = vx(st(0, 1,0,16'h0005,32'h0, 1,0,16'h0006,32'h0, 4'hF),
                 0,1,1,0, 0,0, 32'h0);
    tbl[2]  = vx(st(0, 0,0,16'h0,32'h0, 0,1,16'h0010,32'hA5A51234, 4'hF),
                 1,0,1,1, 1,0, 32'h0);
    tbl[3]  = vx(st(0, 0,0,16'h0,32'h0, 1,0,16'h0010,32'h0, 4'hF),
                 1,0,1,0, 0,0, 32'h0);
    tbl[4]  = vx(idle, 1,1,0,0, 0,1, 32'hA5A51234);
    tbl[5]  = vx(st(0, 0,1,16'h0020,32'hFFFFFFFF, 0,0,16'h0,32'h0, 4'hF),
                 0,1,1,1, 0,0, 32'h0);
    tbl[6]  = vx(st(0, 0,1,16'h0020,32'h00000000, 0,0,16'h0,32'h0, 4'h5),
                 0,1,1,1, 0,0, 32'h0);
    tbl[7]  = vx(st(0, 1,0,16'h0020,32'h0, 0,0,16'h0,32'h0, 4'hF),
                 0,1,1,0, 0,0, 32'h0);
    tbl[8]  = vx(idle, 1,1,0,0, 1,0, 32'hFF00FF00);
    tbl[9]  = vx(st(0, 0,1,16'h9C40,32'h12345678, 0,0,16'h0,32'h0, 4'hF),
                 0,1,0,0, 0,0, 32'h0);
    tbl[10] = vx(st(0, 1,0,16'h9C40,32'h0, 0,0,16'h0,32'h0, 4'hF),
                 0,1,0,0, 0,0, 32'h0);
    tbl[11] = vx(idle, 1,1,0,0, 1,0, 32'h0);
    tbl[12] = vx(st(0, 1,1,16'h0030,32'hDEADBEEF, 0,0,16'h0,32'h0, 4'hF),
                 0,1,1,1, 0,0, 32'h0);
    tbl[13] = vx(st(0, 0,0,16'h0,32'h0, 1,0,16'h0030,32'h0, 4'hF),
                 1,0,1,0, 0,0, 32'h0);
    tbl[14] = vx(idle, 1,1,0,0, 0,1, 32'hDEADBEEF);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(tbl[i].s);
      mdl(tbl[i].s, e);
      chk({t, " wait0"}, 32'(bus.m0_waitrequest), 32'(tbl[i].wq0));
      chk({t, " wait1"}, 32'(bus.m1_waitrequest), 32'(tbl[i].wq1));
      chk({t, " cs"}, 32'(bus.mem_chipselect), 32'(tbl[i].cs));
      chk({t, " mwr"}, 32'(bus.mem_write), 32'(tbl[i].mw));
      chk({t, " rdv0"}, 32'(bus.m0_readdatavalid), 32'(tbl[i].v0));
      chk({t, " rdv1"}, 32'(bus.m1_readdatavalid), 32'(tbl[i].v1));
      if (tbl[i].v0) chk({t, " rd0"}, bus.m0_readdata, tbl[i].rd);
      if (tbl[i].v1) chk({t, " rd1"}, bus.m1_readdata, tbl[i].rd);
    end

    // Fairness: both saturating with reads -> runs of MAXH
    begin
      int c0, c1;
      stim_t s;
      c0 = 0; c1 = 0;
      drive(rsti);
      mdl(rsti, e);
      for (int i = 0; i < 6 * MAXH; i++) begin
        int eg;
        s = st(0, 1,0,16'(i % 64),32'h0, 1,0,16'((i*3) % 64),32'h0, 4'hF);
        drive(s);
        mdl(s, e);
        eg = (i / MAXH) % 2;
        chk($sformatf("fair%0d wait0", i),
            32'(bus.m0_waitrequest), 32'(eg));
        chk($sformatf("fair%0d wait1", i),
            32'(bus.m1_waitrequest), 32'(1 - eg));
        chk_model($sformatf("fair%0d", i), e);
        c0 += int'(bus.m0_readdatavalid);
        c1 += int'(bus.m1_readdatavalid);
      end
      drive(idle);
      mdl(idle, e);
      chk_model("fair_tail", e);
      c0 += int'(bus.m0_readdatavalid);
      c1 += int'(bus.m1_readdatavalid);
      chk("fair rsp count m0", 32'(c0), 32'(3 * MAXH));
      chk("fair rsp count m1", 32'(c1), 32'(3 * MAXH));
    end

    // Read accepted, then reset: response dropped
    begin
      stim_t rd10;
      rd10 = st(0, 1,0,16'h0010,32'h0, 0,0,16'h0,32'h0, 4'hF);
      drive(rd10);
      mdl(rd10, e);
      chk("rstrd issue wait0", 32'(bus.m0_waitrequest), 32'h0);
      drive(rsti);
      mdl(rsti, e);
      chk("rstrd rst rdv0", 32'(bus.m0_readdatavalid), 32'h0);
      chk("rstrd rst wait0", 32'(bus.m0_waitrequest), 32'h1);
      drive(idle);
      mdl(idle, e);
      chk("rstrd after rdv0", 32'(bus.m0_readdatavalid), 32'h0);
      drive(rd10);
      mdl(rd10, e);
      chk("rstrd reissue wait0", 32'(bus.m0_waitrequest), 32'h0);
      drive(idle);
      mdl(idle, e);
      chk("rstrd resp rdv0", 32'(bus.m0_readdatavalid), 32'h1);
      chk("rstrd resp rd0", bus.m0_readdata, 32'hA5A51234);
    end

    // Random traffic vs model
    drive(rsti);
    mdl(rsti, e);
    for (int i = 0; i < 600; i++) begin
      stim_t s;
      int k0, k1;
      k0 = $urandom_range(0, 3);
      k1 = $urandom_range(0, 3);
      s.rst = ($urandom_range(0, 59) == 0);
      s.r0 = k0[0]; s.w0 = k0[1];
      s.r1 = k1[0]; s.w1 = k1[1];
      s.a0 = ($urandom_range(0, 9) == 0) ?
             16'($urandom_range(39995, 40005)) :
             16'($urandom_range(0, 63));
      s.a1 = ($urandom_range(0, 9) == 0) ?
             16'($urandom_range(39995, 40005)) :
             16'($urandom_range(0, 63));
      s.d0 = $urandom;
      s.d1 = $urandom;
      s.be = 4'($urandom_range(0, 15));
      drive(s);
      mdl(s, e);
      chk_model($sformatf("rnd%0d", i), e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
